// File: rtl/ula_seq.sv
// ula_seq: handshaked W-bit ALU with registered result and flags.
// Define ULA_MUL_EN to enable the iterative shift-add multiplier (op 8).
module ula_seq #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [3:0]   i_op,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  output logic [W-1:0] o_s,
  output logic [W-1:0] o_s_hi,
  output logic         o_flag_z,
  output logic         o_flag_c,
  output logic         o_flag_n,
  output logic         o_flag_v,
  output logic         o_err,
  output logic         o_out_valid,
  input  logic         i_out_ready
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SHL = 4'd2;
  localparam logic [3:0] OP_SHR = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd1
`ifdef ULA_MUL_EN
    , S_BUSY = 2'd2
`endif
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         w_accept;
  logic [W:0]   w_add;
  logic [W:0]   w_sub;
  logic [W-1:0] w_res;
  logic         w_c;
  logic         w_v;
  logic         w_err;
  logic         w_is_mul;

  assign w_accept = i_in_valid && o_in_ready;
  assign w_add    = {1'b0, i_a} + {1'b0, i_b};
  assign w_sub    = {1'b0, i_a} - {1'b0, i_b};

`ifdef ULA_MUL_EN
  localparam int CW = $clog2(W + 1);
  localparam logic [3:0] OP_MUL = 4'd8;

  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_mcand;
  logic [W-1:0]   r_mplier;
  logic [2*W-1:0] r_prod;
  logic [W-1:0]   r_s_hi;
  logic [W:0]     w_psum;
  logic [2*W-1:0] w_prod_nxt;
  logic           w_mul_last;

  assign w_is_mul   = (i_op == OP_MUL);
  assign w_mul_last = (r_state == S_BUSY) && (r_cnt == '0);
  assign w_psum     = {1'b0, r_prod[2*W-1:W]}
                    + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_nxt = {w_psum, r_prod[W-1:1]};
  assign o_s_hi     = r_s_hi;

  // Multiplier: load at accept, one shift-add step per BUSY cycle
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
    end else if (w_accept && w_is_mul) begin
      r_cnt    <= CW'(W - 1);
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_prod   <= '0;
    end else if (r_state == S_BUSY) begin
      r_prod   <= w_prod_nxt;
      r_mplier <= r_mplier >> 1;
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end
`else
  assign w_is_mul = 1'b0;
  assign o_s_hi   = '0;
`endif

  // Single-cycle datapath; anything not decoded here is illegal
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_res = w_add[W-1:0];
        w_c   = w_add[W];
        w_v   = (i_a[W-1] == i_b[W-1]) && (w_add[W-1] != i_a[W-1]);
      end
      OP_SUB: begin
        w_res = w_sub[W-1:0];
        w_c   = w_sub[W];
        w_v   = (i_a[W-1] != i_b[W-1]) && (w_sub[W-1] != i_a[W-1]);
      end
      OP_SHL:  w_res = i_a << i_b;
      OP_SHR:  w_res = i_a >> i_b;
      OP_AND:  w_res = i_a & i_b;
      OP_OR:   w_res = i_a | i_b;
      OP_XOR:  w_res = i_a ^ i_b;
      OP_NOT:  w_res = ~i_a;
      default: w_err = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef ULA_MUL_EN
          w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
`else
          w_state_nxt = S_DONE;
`endif
        end
      end
`ifdef ULA_MUL_EN
      S_BUSY: if (r_cnt == '0) w_state_nxt = S_DONE;
`endif
      S_DONE: if (i_out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs; in_ready is forced low while reset is held
  always_comb begin
    o_in_ready  = (r_state == S_IDLE) && i_rst_n;
    o_out_valid = (r_state == S_DONE);
  end

  // Result and flag registers, frozen outside the load edges
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_s      <= '0;
      o_flag_z <= 1'b0;
      o_flag_c <= 1'b0;
      o_flag_n <= 1'b0;
      o_flag_v <= 1'b0;
      o_err    <= 1'b0;
`ifdef ULA_MUL_EN
      r_s_hi   <= '0;
`endif
    end else if (w_accept && !w_is_mul) begin
      o_s      <= w_res;
      o_flag_z <= (w_res == '0);
      o_flag_c <= w_c;
      o_flag_n <= w_res[W-1];
      o_flag_v <= w_v;
      o_err    <= w_err;
`ifdef ULA_MUL_EN
      r_s_hi   <= '0;
    end else if (w_mul_last) begin
      o_s      <= w_prod_nxt[W-1:0];
      r_s_hi   <= w_prod_nxt[2*W-1:W];
      o_flag_z <= (w_prod_nxt[W-1:0] == '0);
      o_flag_c <= 1'b0;
      o_flag_n <= w_prod_nxt[W-1];
      o_flag_v <= 1'b0;
      o_err    <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: vector table plus reset and backpressure sequences.
// Expected results travel through a scoreboard queue.
module tb_ula_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready;
  logic [W-1:0] s;
  logic [W-1:0] s_hi;
  logic         fz, fc, fn, fv, err, out_valid;

  ula_seq #(.W(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_a         (a),
    .i_b         (b),
    .i_op        (op),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_s         (s),
    .o_s_hi      (s_hi),
    .o_flag_z    (fz),
    .o_flag_c    (fc),
    .o_flag_n    (fn),
    .o_flag_v    (fv),
    .o_err       (err),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic [W-1:0] s_hi;
    logic         z, c, n, v, err;
    int           lat;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];
  vec_t sb [$];
  int   ntests = 0;
  int   nfail  = 0;

  function automatic vec_t mk(input logic [3:0] o,
                              input logic [W-1:0] xa, xb, xs, xh,
                              input logic z, c, n, v, e,
                              input int l);
    vec_t r;
    r.op = o; r.a = xa; r.b = xb; r.s = xs; r.s_hi = xh;
    r.z = z; r.c = c; r.n = n; r.v = v; r.err = e; r.lat = l;
    return r;
  endfunction

  function automatic logic [31:0] pk(input vec_t e);
    return 32'({e.s_hi, e.s, e.z, e.c, e.n, e.v, e.err});
  endfunction

  function automatic logic [31:0] dut_pk();
    return 32'({s_hi, s, fz, fc, fn, fv, err});
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_op(input int idx, input vec_t v);
    int   lat;
    vec_t e;
    @(negedge clk);
    a = v.a; b = v.b; op = v.op; in_valid = 1'b1;
    lat = 0;
    while (!in_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d_accept_wait", idx), 32'(in_ready), 32'd1);
    sb.push_back(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d_overlap", idx), 32'(in_ready & out_valid), 32'd0);
    if (out_valid && out_ready && sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("v%0d_result", idx), dut_pk(), pk(e));
    end else begin
      chk($sformatf("v%0d_no_output", idx), 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d_ready_after", idx),
        32'({in_ready, out_valid}), 32'b10);
  endtask

  initial begin : main
    vec_t e;
    // op a b | s s_hi z c n v err | latency
    tbl[0]  = mk(4'd0,  4'd9,  4'd8,  4'd1,  4'd0, 0, 1, 0, 1, 0, 1);
    tbl[1]  = mk(4'd1,  4'd3,  4'd5,  4'd14, 4'd0, 0, 1, 1, 0, 0, 1);
    tbl[2]  = mk(4'd2,  4'd3,  4'd4,  4'd0,  4'd0, 1, 0, 0, 0, 0, 1);
    tbl[3]  = mk(4'd3,  4'd12, 4'd2,  4'd3,  4'd0, 0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(4'd4,  4'd15, 4'd5,  4'd5,  4'd0, 0, 0, 0, 0, 0, 1);
    tbl[5]  = mk(4'd5,  4'd10, 4'd5,  4'd15, 4'd0, 0, 0, 1, 0, 0, 1);
    tbl[6]  = mk(4'd6,  4'd10, 4'd6,  4'd12, 4'd0, 0, 0, 1, 0, 0, 1);
    tbl[7]  = mk(4'd7,  4'd5,  4'd9,  4'd10, 4'd0, 0, 0, 1, 0, 0, 1);
    tbl[8]  = mk(4'd12, 4'd7,  4'd7,  4'd0,  4'd0, 1, 0, 0, 0, 1, 1);
    tbl[9]  = mk(4'd4,  4'd15, 4'd5,  4'd5,  4'd0, 0, 0, 0, 0, 0, 1);
    tbl[10] = mk(4'd0,  4'd7,  4'd1,  4'd8,  4'd0, 0, 0, 1, 1, 0, 1);
    tbl[11] = mk(4'd1,  4'd8,  4'd1,  4'd7,  4'd0, 0, 0, 0, 1, 0, 1);
    tbl[12] = mk(4'd1,  4'd5,  4'd5,  4'd0,  4'd0, 1, 0, 0, 0, 0, 1);
    tbl[13] = mk(4'd3,  4'd9,  4'd7,  4'd0,  4'd0, 1, 0, 0, 0, 0, 1);
`ifdef ULA_MUL_EN
    tbl[14] = mk(4'd8,  4'd13, 4'd11, 4'd15, 4'd8, 0, 0, 1, 0, 0, W + 1);
    tbl[15] = mk(4'd8,  4'd3,  4'd5,  4'd15, 4'd0, 0, 0, 1, 0, 0, W + 1);
`else
    tbl[14] = mk(4'd8,  4'd13, 4'd11, 4'd0,  4'd0, 1, 0, 0, 0, 1, 1);
    tbl[15] = mk(4'd8,  4'd3,  4'd5,  4'd0,  4'd0, 1, 0, 0, 0, 1, 1);
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {dut_pk(), out_valid}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++) do_op(i, tbl[i]);

    // Reset in the middle of a multiply, result must be dropped
    @(negedge clk);
    out_ready = 1'b0;
    a = 4'd3; b = 4'd5; op = 4'd8; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_outputs", {out_valid, s, err, s_hi}, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    chk("midrst_release_ready", 32'(in_ready), 32'd1);
    do_op(100, tbl[0]);

    // Backpressure: result frozen while inputs churn
    @(negedge clk);
    out_ready = 1'b0;
    a = 4'd10; b = 4'd6; op = 4'd6; in_valid = 1'b1;
    sb.push_back(tbl[6]);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); op = 4'($urandom);
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("bp%0d_hold", k), dut_pk(), pk(tbl[6]));
      chk($sformatf("bp%0d_hs", k), 32'({in_ready, out_valid}), 32'b01);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("bp_result", dut_pk(), pk(e));
    end else begin
      chk("bp_sb_empty", 32'(sb.size()), 32'd1);
    end
    @(posedge clk); #1;
    chk("bp_consumed", 32'({in_ready, out_valid}), 32'b10);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ula_seq.md
# ula_seq

Parametrised, handshaked successor to the team's 4-bit combinational ULA. It performs the same eight operations on W-bit operands, with registered results, status flags and a valid/ready handshake on both sides. An optional iterative shift-add multiplier adds a multi-cycle operation. It sits between an operand source (register file or sequencer) and a result sink, one operation in flight at a time.

## Interface
- W, 4: operand/result width; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- a  input  W  operand A.
- b  input  W  operand B; also the shift amount for SHL/SHR.
- op  input  4  opcode: 0 ADD, 1 SUB, 2 SHL, 3 SHR, 4 AND, 5 OR, 6 XOR, 7 NOT A, 8 MUL; 9..15 illegal.
- in_valid  input  1  operands and op valid.
- in_ready  output  1  block accepts operands; high only in IDLE and only while rst_n=1.
- s  output  W  result (low half for MUL).
- s_hi  output  W  high half of MUL product; 0 for all other ops.
- flag_z, flag_c, flag_n, flag_v  output  1 each  zero, carry/borrow, negative, signed overflow.
- err  output  1  illegal opcode flag for the current result.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  sink accepts the result.

## Operation
- FSM states: IDLE, BUSY, DONE.
- Accept occurs on any edge where in_valid && in_ready. At accept, a, b and op are captured.
- Single-cycle ops (0..7, illegal): IDLE -> DONE at accept. The result and flags register at the accept edge.
- MUL: IDLE -> BUSY at accept. Product register {hi, lo} is cleared, and the multiplier and multiplicand are loaded.
  - One shift-add step per cycle for W cycles. A counter of $clog2(W+1) bits runs W-1 down to 0.
  - BUSY -> DONE on the edge that completes step W.
  - s gets the low W bits of the unsigned 2W-bit product, and s_hi gets the high W bits.
- DONE: s, s_hi, flags and err are held stable while out_valid=1. DONE -> IDLE on the edge where out_ready=1.
- Arithmetic is modulo 2^W.
  - ADD: flag_c is the carry out of bit W-1.
  - SUB: flag_c is the borrow (1 when a < b unsigned).
  - flag_v is the two's-complement overflow for ADD/SUB and 0 otherwise.
- SHL/SHR: logical shifts by b. If b >= W the result is 0, and flag_c is 0 for shifts.
- AND/OR/XOR/NOT/MUL: flag_c=0, flag_v=0.
- flag_z = (s == 0), flag_n = s[W-1]. For MUL both are computed on s only.
- Illegal opcodes: s=0, s_hi=0, flags=0 except flag_z=1, err=1. The op still completes through DONE.
- Inputs are ignored outside accept edges. Changing a/b/op while busy has no effect.

## Timing
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - s, s_hi, all flags, err and out_valid go to 0.
  - in_ready is 0 while rst_n=0 and 1 from the first cycle after release.
  - Reset in BUSY or DONE aborts the operation and drops the result.
- Single-cycle op latency: out_valid is high in the cycle after accept.
- MUL latency: out_valid is high W+1 cycles after accept (W=4 gives 5).
- Throughput: after the out_valid && out_ready edge, in_ready is high in the next cycle. There is no overlap, so the best case is one op every 2 cycles.
- in_ready and out_valid are never high in the same cycle.
- If out_ready is held low, DONE persists indefinitely with the outputs frozen.
- in_valid arriving during BUSY/DONE is not accepted. The source must hold it until in_ready.

## Configuration
- ULA_MUL_EN defined: opcode 8 is the iterative multiplier described above, and state BUSY exists.
- ULA_MUL_EN undefined:
  - The multiplier, counter and BUSY state are removed.
  - Opcode 8 is treated as illegal (err=1, s=0).
  - s_hi is tied to 0.

## Test plan
- W=4, reset mid-MUL: accept MUL a=3,b=5, assert rst_n=0 at cycle 2 -> next cycle out_valid=0, s=0, err=0; in_ready=1 one cycle after release.
- W=4, ADD a=9,b=8, out_ready=1 -> next cycle s=1, flag_c=1, flag_v=1, flag_z=0, flag_n=0; in_ready=1 the cycle after.
- W=4, SUB a=3,b=5 -> s=14, flag_c=1, flag_n=1, flag_v=0; SHL a=3,b=4 -> s=0, flag_z=1.
- W=4 with ULA_MUL_EN, MUL a=13,b=11 -> out_valid exactly 5 cycles after accept, s=15, s_hi=8, flag_c=0; without the macro, same stimulus -> 1-cycle latency, s=0, err=1, flag_z=1.
- Backpressure: XOR a=10,b=6 with out_ready=0 for 4 cycles, a/b/op toggled randomly with in_valid=1 -> s=12 held stable, in_ready=0 throughout, result consumed on the first out_ready=1 edge.
- Illegal op=12 -> s=0, s_hi=0, err=1, flag_z=1; the next legal op (AND a=15,b=5 -> s=5) clears err.
